// File: rtl/dmem_mmio_pkg.sv
// Shared MMIO register map and TX_STATUS field positions for dmem_mmio_responder.
package dmem_mmio_pkg;

  // Word offsets within the MMIO window (addr[15:0], bits [1:0] ignored)
  localparam logic [15:0] OFF_CYCLE     = 16'h0000;
  localparam logic [15:0] OFF_TX_DATA   = 16'h0004;
  localparam logic [15:0] OFF_TX_STATUS = 16'h0008;
  localparam logic [15:0] OFF_TX_DROP   = 16'h000C;

  // TX_STATUS layout
  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_COUNT_LSB = 2;
  localparam int unsigned STATUS_COUNT_W   = 7;

endpackage

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Transmit FIFO, synchronous push/pop, head shown registered-only (no bypass).
// Ports:
//   clk, reset (async active-low)
//   push/push_data : write request; accepted when not full or when popping
//   pop            : consumer takes head; ignored while empty
//   head           : oldest entry, 0 when empty
//   empty/full/count : occupancy, pre-edge state
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

  // A full FIFO still takes a push when the head leaves on the same edge
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // Storage is not reset; only entries below count are ever observed
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus MMIO cycle counter and TX FIFO.
// Ports:
//   clk, reset (async active-low)
//   mem_write_mem, alu_result_mem, write_data_mem : MEM-stage access
//   read_data_mem : combinational read data, same cycle
//   tx_data, tx_valid, tx_ready : FIFO drain handshake
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_mem,
  output logic [31:0] read_data_mem,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [31:0]       r_ram [RAM_WORDS];
  logic [31:0]       r_cycle;
  logic [31:0]       r_tx_drop;
  logic              w_is_mmio;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_tx_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  logic [31:0]       w_status;
  logic              w_unused;

  // Address decode; byte-lane bits are ignored (word access only)
  assign w_is_mmio = (alu_result_mem[31:16] == MMIO_BASE);
  assign w_off     = {alu_result_mem[15:2], 2'b00};
  assign w_ram_idx = alu_result_mem[RAM_AW+1:2];
  assign w_unused  = ^alu_result_mem[1:0];

  assign w_tx_push = mem_write_mem && w_is_mmio && (w_off == OFF_TX_DATA);
  assign w_pop     = tx_valid && tx_ready;
  assign w_drop    = w_tx_push && w_full && !w_pop;

  assign tx_valid  = !w_empty;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_tx_push),
    .push_data (write_data_mem),
    .pop       (w_pop),
    .head      (tx_data),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (mem_write_mem && !w_is_mmio) r_ram[w_ram_idx] <= write_data_mem;
  end

  // Free-running cycle counter and saturating drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle   <= '0;
      r_tx_drop <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_drop && (r_tx_drop != 32'hFFFF_FFFF)) r_tx_drop <= r_tx_drop + 32'd1;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[STATUS_EMPTY_BIT] = w_empty;
    w_status[STATUS_FULL_BIT]  = w_full;
    w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(w_count);
  end

  // Read mux; unmapped and write-only offsets return 0
  always_comb begin
    read_data_mem = '0;
    if (!w_is_mmio) begin
      read_data_mem = r_ram[w_ram_idx];
    end else begin
      case (w_off)
        OFF_CYCLE:     read_data_mem = r_cycle;
        OFF_TX_STATUS: read_data_mem = w_status;
        OFF_TX_DROP:   read_data_mem = r_tx_drop;
        default:       read_data_mem = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
`timescale 1ns/1ps
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_DROP   = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_mem;
  logic [31:0] read_data_mem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  dmem_mmio_responder #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (4),
    .MMIO_BASE  (16'hFFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_write_mem  (mem_write_mem),
    .alu_result_mem (alu_result_mem),
    .write_data_mem (write_data_mem),
    .read_data_mem  (read_data_mem),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #50 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Step to just after the next falling edge (mid-cycle)
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    mem_write_mem  = 1'b0;
    alu_result_mem = addr;
    #1;
    chk(name, read_data_mem, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_write_mem  = 1'b1;
    alu_result_mem = addr;
    write_data_mem = data;
    cyc();
    mem_write_mem  = 1'b0;
  endtask

  task automatic push(input logic [31:0] data, input logic accept);
    if (accept) exp_q.push_back(data);
    wr(A_TXDATA, data);
  endtask

  // Monitor: every handshake pops the next expected word
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      #40;
      if (reset && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_unexpected: got %h expected no transfer", tx_data);
        end else begin
          exp = exp_q.pop_front();
          chk("tx_pop", tx_data, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    mem_write_mem  = 1'b0;
    alu_result_mem = '0;
    write_data_mem = '0;
    tx_ready       = 1'b0;
    #20;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    rd(A_CYCLE,  32'd0, "rst_cycle");
    rd(A_STATUS, 32'h1, "rst_status");
    rd(A_DROP,   32'd0, "rst_drop");

    // CYCLE counts edges after release
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    rd(A_CYCLE, 32'd10, "cycle_10");

    // Wrap
    force dut.r_cycle = 32'hFFFF_FFFF;
    rd(A_CYCLE, 32'hFFFF_FFFF, "cycle_max");
    release dut.r_cycle;
    cyc();
    rd(A_CYCLE, 32'd0, "cycle_wrap");
    wr(A_CYCLE, 32'h1234);
    rd(A_CYCLE, 32'd1, "cycle_ro_write");
    cyc();
    rd(A_CYCLE, 32'd2, "cycle_continue");

    // RAM with aliasing and ignored byte bits
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
    wr(32'h0000_0014, 32'h1234_5678);
    rd(32'h0000_0017, 32'h1234_5678, "ram_byte_bits");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_keep");

    // Unmapped and write-only MMIO
    wr(32'hFFFF_0020, 32'h55);
    rd(32'hFFFF_0020, 32'd0, "unmapped");
    rd(A_TXDATA, 32'd0, "txdata_read");

    // Fill with no consumer; head visible only after the push edge
    mem_write_mem  = 1'b1;
    alu_result_mem = A_TXDATA;
    write_data_mem = 32'd1;
    exp_q.push_back(32'd1);
    #1;
    chk("no_bypass_valid", 32'(tx_valid), 32'd0);
    cyc();
    mem_write_mem = 1'b0;
    chk("head_after_push", tx_data, 32'd1);
    push(32'd2, 1'b1);
    push(32'd3, 1'b1);
    push(32'd4, 1'b1);
    rd(A_STATUS, 32'h12, "status_full");
    push(32'd5, 1'b0);
    rd(A_DROP, 32'd1, "drop_1");
    rd(A_STATUS, 32'h12, "status_still_full");
    chk("head_still_1", tx_data, 32'd1);

    // Drain
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("drained_valid", 32'(tx_valid), 32'd0);
    chk("drained_data", tx_data, 32'd0);
    rd(A_STATUS, 32'h1, "status_empty");
    tx_ready = 1'b0;
    // Ready with empty FIFO must do nothing
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    rd(A_STATUS, 32'h1, "empty_ready_ignored");

    // Full with simultaneous pop and push
    push(32'd1, 1'b1);
    push(32'd2, 1'b1);
    push(32'd3, 1'b1);
    push(32'd4, 1'b1);
    tx_ready = 1'b1;
    push(32'd9, 1'b1);
    tx_ready = 1'b0;
    rd(A_STATUS, 32'h12, "full_pop_status");
    chk("full_pop_head", tx_data, 32'd2);
    rd(A_DROP, 32'd1, "full_pop_drop");
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    tx_ready = 1'b0;
    chk("drain2_valid", 32'(tx_valid), 32'd0);
    rd(A_DROP, 32'd1, "drop_unchanged");

    // Reset mid-operation: 3 queued, TX_DROP = 2
    push(32'hA1, 1'b1);
    push(32'hA2, 1'b1);
    push(32'hA3, 1'b1);
    push(32'hA4, 1'b1);
    push(32'hA5, 1'b0);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    rd(A_STATUS, 32'h0C, "pre_rst_status");
    rd(A_DROP, 32'd2, "pre_rst_drop");
    #5;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_data", tx_data, 32'd0);
    exp_q.delete();
    cyc();
    reset = 1'b1;
    rd(A_STATUS, 32'h1, "post_rst_status");
    rd(A_DROP, 32'd0, "post_rst_drop");
    rd(A_CYCLE, 32'd0, "post_rst_cycle");
    cyc();
    rd(A_CYCLE, 32'd1, "post_rst_cycle1");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_survives_rst");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the core's data-memory port: receives the MEM-stage address, write data and write strobe, and returns read data combinationally in the same cycle, in time for the MEM/WB register.
- Contains a word-addressed RAM, a free-running cycle counter and a transmit FIFO.
- The FIFO is drained by an external valid/ready consumer, such as a future UART or a testbench sink.
- Sits at top level beside the core, replacing the plain data memory.

Parameters:
- RAM_WORDS, 64: RAM depth in 32-bit words; must be a power of 2.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of 2 and at least 2.
- MMIO_BASE, 16'hFFFF: value of addr[31:16] that selects the MMIO region.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- mem_write_mem  in  1  write strobe from the core's MEM stage.
- alu_result_mem  in  32  byte address from the core.
- write_data_mem  in  32  store data from the core.
- read_data_mem  out  32  combinational read data to the core.
- tx_data  out  32  FIFO head word.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer accepts the head word this cycle.

Behaviour:
- Decode: MMIO is selected when addr[31:16] == MMIO_BASE; otherwise the access goes to RAM. Bits [1:0] are ignored (word access only).
- RAM index: addr[log2(RAM_WORDS)+1:2]. Higher bits alias.
- RAM read: combinational.
- RAM write: on the clock edge when mem_write_mem=1.
- RAM reset: contents are not reset. Reads of unwritten words are X.
- MMIO map, offsets taken from addr[15:0]:
  - 0x0 CYCLE, read-only: 32-bit counter that increments every cycle out of reset and wraps 0xFFFFFFFF→0. A read returns the current, pre-increment value.
  - 0x4 TX_DATA, write-only: a write pushes write_data_mem. Reads return 0.
  - 0x8 TX_STATUS, read-only: bit0 empty, bit1 full, bits[8:2] count (zero-extended), all other bits 0.
  - 0xC TX_DROP, read-only: count of pushes rejected while full; saturates at 0xFFFFFFFF.
  - Any other offset: reads 0, writes ignored. Writes to read-only registers are ignored.
- Pop: occurs when tx_valid && tx_ready.
- Push: an attempted push is accepted if (!full || pop). A rejected push increments TX_DROP.
- Simultaneous push and pop:
  - Full: both occur and count is unchanged.
  - Empty: the push is accepted and no pop occurs, because tx_valid=0.
- FIFO output:
  - tx_valid = !empty.
  - tx_data = head entry when non-empty, 32'h0 when empty.
  - A pushed word becomes visible on tx_data the cycle after the push edge (one-cycle latency). There is no bypass.
  - Words leave in FIFO order. Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Status timing: reads of TX_STATUS and TX_DROP show pre-edge state. A same-cycle push or pop is not reflected until the next cycle.
- Reset values:
  - CYCLE = 0, FIFO empty, TX_DROP = 0.
  - tx_valid = 0, tx_data = 0.
  - read_data_mem shows reset register values for MMIO addresses; RAM state is unaffected by reset.
- Reset mid-operation: assertion immediately empties the FIFO (pending words are lost) and clears the counters, asynchronously, without waiting for a clock edge. The first CYCLE increment happens on the first edge after deassertion.
- tx_ready: ignored while tx_valid=0.
- The block never stalls the core; there is no wait state.

Decomposition:
- Shared package dmem_mmio_pkg: MMIO offset localparams (OFF_CYCLE, OFF_TX_DATA, OFF_TX_STATUS, OFF_TX_DROP) and STATUS bit positions.
- Sub-module tx_fifo (parameter DEPTH, width 32), with ports clk, reset, push, push_data, pop, head, empty, full, count. It implements the accept-when-full-with-pop rule internally.
- Address decode, RAM, CYCLE counter and TX_DROP register live in the top module.

Test Plan:
- RAM access: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF. Read 0x0000_0110 with RAM_WORDS=64 (aliases word 4) → 0xDEADBEEF.
- CYCLE: release reset, wait 10 edges, read 0xFFFF_0000 → 10. Force the counter to 0xFFFFFFFF, clock one edge, read → 0.
- FIFO order and TX_DROP, with tx_ready=0:
  - Push 1, 2, 3, 4: TX_STATUS reads full=1, count=4.
  - Push 5: rejected, TX_DROP=1.
  - Set tx_ready=1: tx_data yields 1, 2, 3, 4 on successive cycles, then tx_valid=0 and tx_data=0.
- Full with simultaneous pop: FIFO full with 1..4, tx_ready=1, push 9 in the same cycle → next cycle count=4, head=2. Draining gives 2, 3, 4, 9. TX_DROP unchanged.
- Reset mid-operation: with 3 words queued and TX_DROP=2, pulse reset low between clock edges → tx_valid=0 immediately; afterwards TX_STATUS shows empty=1, count=0, and TX_DROP and CYCLE read 0.
- Unmapped MMIO: write 0x55 to 0xFFFF_0020, then read it → 0. A write to 0xFFFF_0000 leaves the CYCLE sequence uninterrupted. Reading TX_DATA → 0.
